// File: rtl/dino_pkg.sv
// Shared player-state codes used by the player FSM, sprite ROM and
// collision/scoring logic.
package dino_pkg;

  localparam logic [2:0] PS_RESTART   = 3'b000;
  localparam logic [2:0] PS_JUMPING   = 3'b001;
  localparam logic [2:0] PS_RUN_1     = 3'b010;
  localparam logic [2:0] PS_RUN_2     = 3'b011;
  localparam logic [2:0] PS_DUCKING   = 3'b100;
  localparam logic [2:0] PS_GAME_OVER = 3'b101;

  typedef enum logic [2:0] {
    ST_RESTART   = PS_RESTART,
    ST_JUMPING   = PS_JUMPING,
    ST_RUN_1     = PS_RUN_1,
    ST_RUN_2     = PS_RUN_2,
    ST_DUCKING   = PS_DUCKING,
    ST_GAME_OVER = PS_GAME_OVER
  } player_state_e;

endpackage

// File: rtl/dino_anim_timer.sv
// Tick-enabled mod-TICKS counter with synchronous clear.
// Ports: clk, rst (sync, high), en (count step), clr, wrap (last-count step).
module dino_anim_timer #(
  parameter int unsigned TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count;

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/dino_player_ctrl.sv
// Dino player FSM: state code, height and airborne flag per game tick.
// Ports: clk, rst, i_game_tick, i_jump, i_duck, i_game_over, i_restart,
// o_player_state, o_player_height, o_airborne. Option: DINO_FAST_FALL_EN.
module dino_player_ctrl
  import dino_pkg::*;
#(
  parameter int unsigned HEIGHT_W   = 6,
  parameter int unsigned JUMP_VEL   = 6,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned ANIM_TICKS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_game_tick,
  input  logic                i_jump,
  input  logic                i_duck,
  input  logic                i_game_over,
  input  logic                i_restart,
  output logic [2:0]          o_player_state,
  output logic [HEIGHT_W-1:0] o_player_height,
  output logic                o_airborne
);

  localparam int unsigned VW = HEIGHT_W + 1;
  localparam logic [VW-1:0] JV = VW'(JUMP_VEL);
  localparam logic [VW-1:0] G1 = VW'(GRAVITY);
`ifdef DINO_FAST_FALL_EN
  localparam logic [VW-1:0] G2 = VW'(2 * GRAVITY);
`endif

  player_state_e state_q, state_d;
  logic [HEIGHT_W-1:0] height_q, height_d;
  logic [VW-1:0] vel_q, vel_d;
  logic airborne_q;
  logic anim_en, anim_clr, anim_wrap;
  logic [VW:0] sum;
  logic [VW-1:0] grav;

  dino_anim_timer #(
    .TICKS (ANIM_TICKS)
  ) u_anim (
    .clk  (clk),
    .rst  (rst),
    .en   (anim_en),
    .clr  (anim_clr),
    .wrap (anim_wrap)
  );

  // Height zero-extended, velocity sign-extended: one extra bit
  // keeps the true sum of an unsigned height and signed velocity.
  assign sum = {2'b00, height_q} + {vel_q[VW-1], vel_q};

`ifdef DINO_FAST_FALL_EN
  assign grav = i_duck ? G2 : G1;
`else
  assign grav = G1;
`endif

  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    vel_d    = vel_q;
    anim_en  = 1'b0;
    anim_clr = 1'b0;
    if (i_game_over) begin
      state_d = ST_GAME_OVER;
    end else if (state_q == ST_GAME_OVER) begin
      if (i_restart) begin
        state_d  = ST_RESTART;
        height_d = '0;
        vel_d    = '0;
        anim_clr = 1'b1;
      end
    end else if (i_game_tick) begin
      unique case (state_q)
        ST_RESTART: begin
          state_d  = ST_RUN_1;
          anim_clr = 1'b1;
        end
        ST_RUN_1, ST_RUN_2: begin
          if (i_jump) begin
            state_d  = ST_JUMPING;
            vel_d    = JV;
            height_d = '0;
          end else if (i_duck) begin
            state_d = ST_DUCKING;
          end else begin
            anim_en = 1'b1;
            if (anim_wrap) begin
              state_d = (state_q == ST_RUN_1) ? ST_RUN_2 : ST_RUN_1;
            end
          end
        end
        ST_DUCKING: begin
          if (i_jump) begin
            state_d  = ST_JUMPING;
            vel_d    = JV;
            height_d = '0;
          end else if (!i_duck) begin
            state_d  = ST_RUN_1;
            anim_clr = 1'b1;
          end
        end
        ST_JUMPING: begin
          // Negative or zero sum means touchdown.
          if (sum[VW] || sum == '0) begin
            state_d  = ST_RUN_1;
            height_d = '0;
            vel_d    = '0;
            anim_clr = 1'b1;
          end else begin
            height_d = sum[HEIGHT_W] ? '1 : sum[HEIGHT_W-1:0];
            vel_d    = vel_q - grav;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RESTART;
      height_q   <= '0;
      vel_q      <= '0;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      height_q   <= height_d;
      vel_q      <= vel_d;
      airborne_q <= (state_d == ST_JUMPING);
    end
  end

  assign o_player_state  = state_q;
  assign o_player_height = height_q;
  assign o_airborne      = airborne_q;

endmodule

// File: tb/tb_dino_player_ctrl.sv
// Randomised and directed bench for dino_player_ctrl against a
// behavioural reference model.
module tb_dino_player_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, jump = 1'b0, duck = 1'b0;
  logic       go = 1'b0, restart = 1'b0;
  logic [2:0] st;
  logic [5:0] ht;
  logic       air;

  int errors = 0;
  int checks = 0;

  int m_st = 0, m_h = 0, m_v = 0, m_a = 0;

  always #5 clk = ~clk;

  dino_player_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .i_game_tick     (tick),
    .i_jump          (jump),
    .i_duck          (duck),
    .i_game_over     (go),
    .i_restart       (restart),
    .o_player_state  (st),
    .o_player_height (ht),
    .o_airborne      (air)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: states 0 restart,1 jump,2 run1,3 run2,4 duck,5 over.
  task automatic model_next();
    int s;
    if (rst) begin
      m_st = 0; m_h = 0; m_v = 0; m_a = 0;
    end else if (go) begin
      m_st = 5;
    end else if (m_st == 5) begin
      if (restart) begin
        m_st = 0; m_h = 0; m_v = 0; m_a = 0;
      end
    end else if (tick) begin
      case (m_st)
        0: begin m_st = 2; m_a = 0; end
        2, 3: begin
          if (jump) begin
            m_st = 1; m_v = 6; m_h = 0;
          end else if (duck) begin
            m_st = 4;
          end else begin
            m_a++;
            if (m_a == 4) begin
              m_a = 0;
              m_st = (m_st == 2) ? 3 : 2;
            end
          end
        end
        4: begin
          if (jump) begin
            m_st = 1; m_v = 6; m_h = 0;
          end else if (!duck) begin
            m_st = 2; m_a = 0;
          end
        end
        1: begin
          s = m_h + m_v;
          if (s <= 0) begin
            m_st = 2; m_h = 0; m_v = 0; m_a = 0;
          end else begin
            m_h = (s > 63) ? 63 : s;
`ifdef DINO_FAST_FALL_EN
            m_v = m_v - (duck ? 2 : 1);
`else
            m_v = m_v - 1;
`endif
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit r, input bit t, input bit j,
                     input bit d, input bit g, input bit rs);
    rst = r; tick = t; jump = j; duck = d; go = g; restart = rs;
    model_next();
    @(posedge clk);
    @(negedge clk);
    chk("state", int'(st), m_st);
    chk("height", int'(ht), m_h);
    chk("airborne", int'(air), (m_st == 1) ? 1 : 0);
  endtask

  task automatic tk(input bit j, input bit d);
    cyc(0, 1, j, d, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  int prof[12] = '{6, 11, 15, 18, 20, 21, 21, 20, 18, 15, 11, 6};

  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    chk("lit_reset_state", int'(st), 0);
    chk("lit_reset_height", int'(ht), 0);
    chk("lit_reset_air", int'(air), 0);

    tk(0, 0);
    chk("lit_run1", int'(st), 3'b010);
    for (int i = 0; i < 4; i++) tk(0, 0);
    chk("lit_run2", int'(st), 3'b011);
    for (int i = 0; i < 4; i++) tk(0, 0);
    chk("lit_run1_again", int'(st), 3'b010);

    tk(1, 0);
    chk("lit_jump_state", int'(st), 3'b001);
    chk("lit_jump_air", int'(air), 1);
    for (int i = 0; i < 12; i++) begin
      tk(i[0], 0);
      chk("lit_jump_profile", int'(ht), prof[i]);
    end
    tk(0, 0);
    chk("lit_land_state", int'(st), 3'b010);
    chk("lit_land_height", int'(ht), 0);
    chk("lit_land_air", int'(air), 0);

    tk(1, 1);
    chk("lit_jump_beats_duck", int'(st), 3'b001);
    for (int i = 0; i < 13; i++) tk(0, 0);
    tk(0, 1);
    chk("lit_duck", int'(st), 3'b100);
    tk(0, 1);
    chk("lit_duck_hold", int'(st), 3'b100);
    tk(0, 0);
    chk("lit_duck_release", int'(st), 3'b010);
    for (int i = 0; i < 3; i++) tk(0, 0);
    chk("lit_anim_cleared", int'(st), 3'b010);
    tk(0, 0);
    chk("lit_anim_toggle", int'(st), 3'b011);

    tk(1, 0);
    for (int i = 0; i < 3; i++) tk(0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("lit_over_state", int'(st), 3'b101);
    chk("lit_over_height", int'(ht), 15);
    for (int i = 0; i < 10; i++) tk(1, 0);
    chk("lit_over_frozen", int'(ht), 15);
    cyc(0, 0, 0, 0, 0, 1);
    chk("lit_restart_state", int'(st), 3'b000);
    chk("lit_restart_height", int'(ht), 0);
    tk(0, 0);
    chk("lit_restart_run", int'(st), 3'b010);

    cyc(0, 0, 0, 0, 0, 1);
    chk("lit_restart_ignored", int'(st), 3'b010);
    cyc(0, 1, 0, 0, 1, 1);
    chk("lit_over_beats_restart", int'(st), 3'b101);
    cyc(0, 0, 0, 0, 1, 1);
    chk("lit_over_holds", int'(st), 3'b101);
    cyc(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 1) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 79) == 0),
          ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
